// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: instruction-fetch controller and IF/ID pipeline register.
// Owns the fetch PC and keeps at most one instruction-memory request in flight
// (req/ready handshake). A word that returns during a stall goes into a 1-entry
// buffer. Decode sees either a real instruction or a NOP bubble.
// Optional feature macro: FETCH_PERF_EN adds the stall and bubble counters.
// When the macro is undefined the perf ports are tied to 0.
module fetch_stage_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_f,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_bubble_cnt
);

   // IDLE: one cycle after reset. FETCH: normal request/accept.
   // DISCARD: a redirect hit an unfinished request, so its response is dropped.
   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DISCARD = 2'd2} state_t;

   state_t      state;
   logic [31:0] disc_target;
   logic [31:0] buf_instr;
   logic [31:0] buf_pc;
   logic        buf_valid;
   logic        redirect;
   logic        resp;
   logic        accept;
   logic        bubble_load;

   // Handshake contract: imem_req=1 marks an outstanding request.
   // imem_addr stays stable until the cycle in which imem_ready=1 completes it.
   // That same cycle carries imem_rdata. No new request is raised while the buffer is full.
   assign imem_req    = (state == DISCARD) || ((state == FETCH) && !buf_valid);
   assign imem_addr   = pc_f;
   assign redirect    = branch_taken && !stall;  // a stall masks the branch; hazard unit re-presents it
   assign resp        = imem_req && imem_ready;
   assign accept      = resp && (state == FETCH) && !redirect;  // response kept (not dropped)
   assign bubble_load = !stall && (branch_taken || (!buf_valid && !accept));

   // FSM, redirect-target latch and fetch PC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         disc_target <= RESET_PC;
         pc_f        <= RESET_PC;
      end else begin
         case (state)
            IDLE: begin
               state <= FETCH;
               if (redirect) pc_f <= branch_target;
            end
            FETCH: begin
               if (redirect && imem_req && !imem_ready) begin
                  // request still open: keep its address, remember where to go
                  state       <= DISCARD;
                  disc_target <= branch_target;
               end else if (redirect) begin
                  pc_f <= branch_target;
               end else if (accept) begin
                  pc_f <= pc_f + 32'd4;
               end
            end
            DISCARD: begin
               if (imem_ready) begin
                  state <= FETCH;
                  pc_f  <= redirect ? branch_target : disc_target;
               end else if (redirect) begin
                  disc_target <= branch_target;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // One-entry holding buffer: filled by a word accepted during a stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_valid <= 1'b0;
         buf_instr <= NOP_INSTR;
         buf_pc    <= 32'd0;
      end else if (!stall) begin
         buf_valid <= 1'b0;
      end else if (accept) begin
         buf_valid <= 1'b1;
         buf_instr <= imem_rdata;
         buf_pc    <= pc_f;
      end
   end

   // IF/ID register: redirect bubble > buffered word > fresh word > bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_id_valid <= 1'b0;
         if_id_instr <= NOP_INSTR;
         if_id_pc    <= 32'd0;
         if_id_pc4   <= 32'd0;
      end else if (!stall) begin
         if (branch_taken) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
         end else if (buf_valid) begin
            if_id_valid <= 1'b1;
            if_id_instr <= buf_instr;
            if_id_pc    <= buf_pc;
            if_id_pc4   <= buf_pc + 32'd4;
         end else if (accept) begin
            if_id_valid <= 1'b1;
            if_id_instr <= imem_rdata;
            if_id_pc    <= pc_f;
            if_id_pc4   <= pc_f + 32'd4;
         end else begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
         end
      end
   end

`ifdef FETCH_PERF_EN
   // Performance counters: stall cycles and bubble loads, free-running and wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt  <= 32'd0;
         perf_bubble_cnt <= 32'd0;
      end else begin
         if (stall)       perf_stall_cnt  <= perf_stall_cnt + 32'd1;
         if (bubble_load) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
   end
`else
   assign perf_stall_cnt  = 32'd0;
   assign perf_bubble_cnt = 32'd0;
`endif

endmodule
